// File: rtl/add8_share_ctrl_if.sv
// Request/response bundle between the requesters and the shared 8-bit adder controller.
// Requester i owns bit i of the per-requester vectors and bits [16i+15:16i] of the operands.
interface add8_share_ctrl_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    req_wide;
    logic [16*N_REQ-1:0] req_a;
    logic [16*N_REQ-1:0] req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [16:0]         rsp_sum;

    // Requester side
    modport master (
        output req_valid, req_wide, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    // Controller side
    modport slave (
        input  req_valid, req_wide, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/add8_share_ctrl.sv
// Round-robin controller sharing one combinational 8-bit adder core among N_REQ requesters.
// 8-bit adds take one pass; 16-bit adds take low byte, high byte and, if the low byte
// carried, an increment pass of the high byte. The core's output is used verbatim, so any
// approximation error of the attached add8 variant passes straight through.
module add8_share_ctrl #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    add8_share_ctrl_if.slave   bus,
    output logic               busy,
    output logic [15:0]        op_count,
    // Shared adder core hookup: O = A (+) B, computed combinationally outside this block
    output logic [7:0]         add_a,
    output logic [7:0]         add_b,
    input  logic [8:0]         add_o
);

    typedef enum logic [2:0] {StIdle, StLo, StHi, StInc, StRsp} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;
    logic            wide_q, wide_d;
    logic [7:0]      lo_q, lo_d;
    logic            c_q, c_d;
    logic [8:0]      hi_q, hi_d;
    logic [16:0]     res_q, res_d;
    logic [15:0]     op_count_q, op_count_d;

    logic            grant_found;
    int unsigned     grant_idx;
    int unsigned     scan_idx;
    logic [N_REQ-1:0] req_ready_c;

    // Round-robin search: first valid requester at or after ptr+1, wrapping modulo N_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 0;
        scan_idx    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            scan_idx = (int'(ptr_q) + k) % N_REQ;
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Next-state, datapath updates, adder operand mux and grant strobe
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        wide_d      = wide_q;
        lo_d        = lo_q;
        c_d         = c_q;
        hi_d        = hi_q;
        res_d       = res_q;
        op_count_d  = op_count_q;
        req_ready_c = '0;
        add_a       = 8'h00;
        add_b       = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    req_ready_c[grant_idx] = 1'b1;
                    a_d     = bus.req_a[16*grant_idx +: 16];
                    b_d     = bus.req_b[16*grant_idx +: 16];
                    wide_d  = bus.req_wide[grant_idx];
                    id_d    = ID_W'(grant_idx);
                    ptr_d   = ID_W'(grant_idx);
                    state_d = StLo;
                end
            end
            StLo: begin
                add_a = a_q[7:0];
                add_b = b_q[7:0];
                if (!wide_q) begin
                    res_d   = {8'h00, add_o};
                    state_d = StRsp;
                end else begin
                    lo_d    = add_o[7:0];
                    c_d     = add_o[8];
                    state_d = StHi;
                end
            end
            StHi: begin
                add_a = a_q[15:8];
                add_b = b_q[15:8];
                hi_d  = add_o;
                if (c_q) begin
                    state_d = StInc;
                end else begin
                    // add_o is the value being registered into hi this cycle
                    res_d   = {add_o[8], add_o[7:0], lo_q};
                    state_d = StRsp;
                end
            end
            StInc: begin
                add_a   = hi_q[7:0];
                add_b   = 8'h01;
                res_d   = {hi_q[8] | add_o[8], add_o[7:0], lo_q};
                state_d = StRsp;
            end
            StRsp: begin
                if (bus.rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset beats a simultaneous handshake: the requester must not see an accept
        if (rst) begin
            req_ready_c = '0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            wide_q     <= 1'b0;
            lo_q       <= '0;
            c_q        <= 1'b0;
            hi_q       <= '0;
            res_q      <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            wide_q     <= wide_d;
            lo_q       <= lo_d;
            c_q        <= c_d;
            hi_q       <= hi_d;
            res_q      <= res_d;
            op_count_q <= op_count_d;
        end
    end

    // Response and status outputs; result fields read as zero outside RSP
    always_comb begin
        bus.req_ready = req_ready_c;
        bus.rsp_valid = (state_q == StRsp);
        bus.rsp_sum   = (state_q == StRsp) ? res_q : 17'h0;
        bus.rsp_id    = (state_q == StRsp) ? id_q : '0;
        busy          = (state_q != StIdle);
        op_count      = op_count_q;
    end

endmodule

// File: tb/tb_add8_share_ctrl.sv
// Bench for add8_share_ctrl with an exact adder core; expectations come from plain
// arithmetic on the operands and a round-robin pick over the pending-request mask.
module tb_add8_share_ctrl;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] op_count;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [8:0]  add_o;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [15:0] op_a [N_REQ];
    logic [15:0] op_b [N_REQ];
    logic        op_w [N_REQ];
    int          last_grant = N_REQ - 1;
    int          done_count = 0;

    add8_share_ctrl_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    add8_share_ctrl #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_o    (add_o)
    );

    // Exact add8 stub
    assign add_o = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N_REQ-1:0] mask);
        for (int k = 1; k <= int'(N_REQ); k++) begin
            int idx = (last_grant + k) % int'(N_REQ);
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int id, input logic wide, input logic [15:0] a,
                           input logic [15:0] b);
        op_a[id] = a;
        op_b[id] = b;
        op_w[id] = wide;
        bus.req_a[16*id +: 16] = a;
        bus.req_b[16*id +: 16] = b;
        bus.req_wide[id]       = wide;
        bus.req_valid[id]      = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Serve one grant: check who wins, the latency, the result and the op counter.
    // keep=1 re-issues a fresh random request from the winner, as if it never went idle.
    task automatic serve(input int hold, input logic keep);
        int          exp_id;
        int          t;
        int          lat;
        int          exp_lat;
        logic [16:0] exp_sum;
        logic [7:0]  lo_a;
        logic [7:0]  lo_b;
        #1;
        exp_id = rr_pick(bus.req_valid);
        t = 0;
        while (bus.req_ready == '0 && t < 20) begin
            next_cycle();
            t++;
        end
        if (exp_id < 0) begin
            check("grant_pending", 32'(bus.req_valid), 32'hF);
            return;
        end
        check("grant_onehot", 32'(bus.req_ready), 32'(1 << exp_id));
        if (bus.req_ready != N_REQ'(1 << exp_id)) return;

        lo_a = op_a[exp_id][7:0];
        lo_b = op_b[exp_id][7:0];
        if (op_w[exp_id]) begin
            exp_sum = {1'b0, op_a[exp_id]} + {1'b0, op_b[exp_id]};
            exp_lat = ((9'(lo_a) + 9'(lo_b)) > 9'd255) ? 4 : 3;
        end else begin
            exp_sum = 17'(lo_a) + 17'(lo_b);
            exp_lat = 2;
        end
        last_grant = exp_id;
        bus.rsp_ready = (hold == 0);
        next_cycle();
        if (keep) set_req(exp_id, 1'($urandom), 16'($urandom), 16'($urandom));
        else bus.req_valid[exp_id] = 1'b0;

        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            check("busy_in_flight", 32'(busy), 32'd1);
            next_cycle();
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_sum", 32'(bus.rsp_sum), 32'(exp_sum));
        check("rsp_id", 32'(bus.rsp_id), 32'(exp_id));

        for (int h = 0; h < hold; h++) begin
            next_cycle();
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_sum", 32'(bus.rsp_sum), 32'(exp_sum));
            check("hold_id", 32'(bus.rsp_id), 32'(exp_id));
            check("hold_no_grant", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        next_cycle();
        done_count++;
        check("op_count", 32'(op_count), 32'(done_count & 32'hFFFF));
        check("rsp_done", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        logic [N_REQ-1:0] mask;
        int guard;
        bus.req_valid = '0;
        bus.req_wide  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Reset held 3 cycles with every requester asking
        for (int i = 0; i < int'(N_REQ); i++)
            set_req(i, 1'($urandom), 16'($urandom), 16'($urandom));
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_rsp_outs", {13'd0, bus.rsp_id, bus.rsp_sum}, 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_op_count", 32'(op_count), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("first_grant_req0", 32'(bus.req_ready), 32'd1);
        // Drain all four: order 0,1,2,3
        for (int i = 0; i < int'(N_REQ); i++) serve(0, 1'b0);

        // Narrow op from requester 2
        set_req(2, 1'b0, 16'h00F0, 16'h0020);
        serve(0, 1'b0);
        check("narrow_sum_const", 32'(op_a[2][7:0] + op_b[2][7:0]), 32'h110);

        // Wide ops from requester 1: carry into high byte, then full 17-bit overflow
        set_req(1, 1'b1, 16'h12FF, 16'h0301);
        serve(0, 1'b0);
        set_req(1, 1'b1, 16'hFFFF, 16'h0001);
        serve(0, 1'b0);
        // Wide op without low-byte carry
        set_req(1, 1'b1, 16'h1234, 16'h0101);
        serve(0, 1'b0);

        // Fairness with all continuously valid; second response backpressured 5 cycles
        for (int i = 0; i < int'(N_REQ); i++)
            set_req(i, 1'($urandom), 16'($urandom), 16'($urandom));
        for (int g = 0; g < 5; g++) serve((g == 1) ? 5 : 0, 1'b1);
        bus.req_valid = '0;
        next_cycle();

        // Random subsets of requesters with random widths, operands and backpressure
        for (int r = 0; r < 15; r++) begin
            mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < int'(N_REQ); i++)
                if (mask[i]) set_req(i, 1'($urandom), 16'($urandom), 16'($urandom));
            guard = 0;
            while (bus.req_valid != '0 && guard < 10) begin
                serve($urandom_range(0, 2), 1'b0);
                guard++;
            end
        end

        // Reset while requester 3's wide op is in HI
        set_req(3, 1'b1, 16'($urandom), 16'($urandom));
        #1;
        guard = 0;
        while (bus.req_ready == '0 && guard < 10) begin
            next_cycle();
            guard++;
        end
        check("grant_req3", 32'(bus.req_ready), 32'h8);
        next_cycle();
        bus.req_valid[3] = 1'b0;
        next_cycle();
        check("busy_in_hi", 32'(busy), 32'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        done_count = 0;
        last_grant = N_REQ - 1;
        check("midrst_op_count", 32'(op_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 5; c++) begin
            check("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
            next_cycle();
        end
        // Simultaneous 0 and 3: 0 goes first
        set_req(0, 1'($urandom), 16'($urandom), 16'($urandom));
        set_req(3, 1'($urandom), 16'($urandom), 16'($urandom));
        #1;
        check("post_rst_grant0", 32'(bus.req_ready), 32'd1);
        serve(0, 1'b0);
        serve(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/add8_share_ctrl.md
# add8_share_ctrl

Round-robin controller that shares one combinational 8-bit approximate adder core among `N_REQ` requesters. It sequences 8-bit adds as single passes and 16-bit adds as two or three passes: low byte, high byte, then a conditional carry increment. It returns registered results over a valid/ready response channel. It sits between accelerator-side requesters and a single `add8_*` instance, chosen at integration time, with ports `A[7:0]`, `B[7:0]`, `O[8:0]`.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `ID_W`, 2, width of requester id; must equal ceil(log2(`N_REQ`))

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous and active-high
- `req_valid`  in  `N_REQ`  per-requester request valid
- `req_ready`  out  `N_REQ`  one-hot grant / accept strobe
- `req_wide`  in  `N_REQ`  per requester: 0 = 8-bit add, 1 = 16-bit add
- `req_a`  in  16*`N_REQ`  operand A; requester i uses bits [16i+15:16i]; 8-bit ops use the low byte
- `req_b`  in  16*`N_REQ`  operand B; same packing as `req_a`
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  result consumer ready
- `rsp_id`  out  `ID_W`  index of the requester that owns the result
- `rsp_sum`  out  17  result; 8-bit ops return zero-extended `O[8:0]`
- `busy`  out  1  high whenever state is not IDLE
- `op_count`  out  16  number of completed responses; wraps at 0xFFFF→0

## Operation
- FSM states: IDLE, LO, HI, INC, RSP.
- **IDLE:**
  - If any `req_valid` is high, grant the first valid requester at or after `ptr+1` (mod `N_REQ`).
  - Drive that requester's `req_ready` bit high for that one cycle, combinationally from `req_valid` and state.
  - Capture a, b, wide and id into registers. Set `ptr` to the granted id. Go to LO.
  - `req_ready` is all-zero in every other state.
- **Adder inputs** always come from registers, never directly from request ports.
- **LO:**
  - Adder inputs: `A`=a[7:0], `B`=b[7:0].
  - Narrow op: `res`←{8'h00, O[8:0]}, go to RSP.
  - Wide op: `lo`←O[7:0], `c`←O[8], go to HI.
- **HI:**
  - Adder inputs: `A`=a[15:8], `B`=b[15:8]. Register `hi`←O[8:0].
  - If `c`=1, go to INC. Otherwise `res`←{hi[8], hi[7:0], lo} and go to RSP.
- **INC:**
  - Adder inputs: `A`=hi[7:0], `B`=8'h01.
  - `res`←{hi[8] | O[8], O[7:0], lo}. Go to RSP.
- **RSP:**
  - `rsp_valid`=1; `rsp_sum`=`res` and `rsp_id`=id, held stable until `rsp_ready`.
  - On `rsp_valid` & `rsp_ready`: increment `op_count` and go to IDLE.
- **Adder error:** approximation error is passed through unmodified. The controller adds no correction; every pass uses the core's `O` verbatim.
- **Requester rules:** a requester keeps `req_valid` and its operands stable until its `req_ready` bit is seen. Requesters that are not granted keep waiting; no request is dropped.
- **Fairness:** with k requesters continuously valid, each one is granted exactly once in every k consecutive grants.

## Timing
- **Reset values:** state=IDLE, `ptr`=`N_REQ`-1 (so requester 0 has first priority). All outputs are 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_sum`, `busy`, `op_count`. Internal `res`, `lo`, `hi`, `c` are also 0.
- **Latency**, with the handshake in cycle T and `rsp_ready`=1:
  - narrow op: `rsp_valid` in T+2
  - wide op with `c`=0: T+3
  - wide op with `c`=1: T+4
- **Throughput:** a new grant is possible earliest in the cycle after the response handshake, because RSP→IDLE takes one cycle. There is no overlap between operations.
- **Backpressure:** `rsp_ready`=0 holds RSP indefinitely, with outputs constant and `req_ready` all-zero.
- **Reset mid-operation:** `rst` high in any state returns everything to reset values on the next edge. The in-flight operation is discarded and no response is issued. The requester already handshook and does not retry automatically.
- **Simultaneous reset and handshake:** reset wins; no grant is recorded.
- **Critical path:** operand register mux → adder core → result register, within one cycle.

## Test plan
The bench binds an exact `add8` stub (O=A+B) for these directed value checks.
- **Reset:** hold `rst` 3 cycles with all `req_valid`=1 → all outputs 0 and `req_ready`=0 during reset; after release, first grant goes to requester 0.
- **Narrow op:** requester 2, narrow, a=0x00F0, b=0x0020, handshake at T → `rsp_valid` at T+2 with `rsp_sum`=0x00110, `rsp_id`=2, `op_count`=1 after the handshake.
- **Wide op with carry:** requester 1, a=0x12FF, b=0x0301 → LO gives c=1, INC executed; `rsp_sum`=0x01600 at T+4. Repeat with a=0xFFFF, b=0x0001 → `rsp_sum`=0x10000.
- **Wide op without carry:** a=0x1234, b=0x0101 → `rsp_sum`=0x01335 at T+3; INC never entered (`busy` high for 3 cycles).
- **Fairness and backpressure:** all 4 requesters continuously valid (N_REQ=4) → grant order 0,1,2,3,0. In the second response, drop `rsp_ready` for 5 cycles → `rsp_sum`/`rsp_id` stable, no new `req_ready`.
- **Reset during HI:** assert `rst` for 1 cycle while in HI of a wide op from requester 3 → no `rsp_valid`; next simultaneous requests from 0 and 3 grant 0 first.
